nms_keypoint_packer: RTL
========================

# nms_keypoint_packer

Consumer-side block for the NMS score stream. Takes the suppressed per-pixel score stream with its `V_SYNC` / `data_en` framing and keeps only the non-zero scores (surviving corners). Each survivor becomes an (x, y, score) keypoint record in an internal FIFO, drained through a valid/ready port. Sits between the NMS output and the keypoint DMA/UART formatter, and also reports a per-frame keypoint count and an overflow count.

## Interface
Parameters:
- `FIFO_DEPTH`, 16, keypoint FIFO entries; power of two, ≥ 2.
- `COORD_W`, 11, coordinate width; matches `width` / `height`.
- `SCORE_W`, 8, score width.

Ports:
- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_V_SYNC`  in  1  frame-active level from NMS; high for the whole frame.
- `in_data_en`  in  1  pixel-valid from NMS.
- `in_score`  in  SCORE_W  suppressed score; 0 means not a corner.
- `TVALID_in`  in  1  pipeline advance; when 0 the input side is frozen.
- `width`  in  COORD_W  pixels per line; static during a frame; ≥ 1.
- `kp_valid`  out  1  record available.
- `kp_ready`  in  1  sink accepts the record.
- `kp_x`  out  COORD_W  column of the keypoint, 0-based.
- `kp_y`  out  COORD_W  row of the keypoint, 0-based.
- `kp_score`  out  SCORE_W  keypoint score.
- `frame_done`  out  1  one-cycle pulse at end of frame.
- `frame_kp_count`  out  16  keypoints detected in the last finished frame, whether enqueued or dropped.
- `overflow_cnt`  out  16  saturating count of dropped keypoints since reset.

## Operation
- **Input qualification:**
  - Every input-side register (sync history, counters, capture stage) updates only when `TVALID_in`=1.
  - An accepted pixel needs `TVALID_in`=1 and `in_data_en`=1.
- **Frame start:** on a rising edge of `in_V_SYNC` (registered previous value 0, current value 1, with `TVALID_in`=1):
  - x ← 0, y ← 0, running count ← 0.
  - A pixel accepted in that same cycle is column 0 of row 0.
- **Coordinates:**
  - Each accepted pixel uses the current (x, y), then advances.
  - If x = width−1: x ← 0 and y ← y+1. Otherwise x ← x+1.
  - y wraps modulo 2^COORD_W; it has no height limit.
- **Detection:**
  - An accepted pixel with `in_score` ≠ 0 goes into a capture register (x, y, score, push flag).
  - The running count increments, saturating at 0xFFFF.
- **Enqueue:** the next cycle, if the push flag is set:
  - Written to the FIFO if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise dropped, and `overflow_cnt` increments (saturating).
- **Dequeue:**
  - Pop happens when `kp_valid` && `kp_ready`.
  - `kp_x` / `kp_y` / `kp_score` show the FIFO head (show-ahead).
  - Outputs are held stable while `kp_valid`=1 and `kp_ready`=0.
  - The output side ignores `TVALID_in`.
- **Frame end:** on a falling edge of `in_V_SYNC` (with `TVALID_in`=1):
  - `frame_kp_count` ← running count; this includes a detection made in the same cycle.
  - `frame_done` pulses for 1 cycle.
- **FIFO structure:** read/write pointers one bit wider than log2(FIFO_DEPTH).
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the rest are equal.

## Timing
- **Reset values:** all outputs 0: `kp_valid`, `kp_x`, `kp_y`, `kp_score`, `frame_done`, `frame_kp_count`, `overflow_cnt`. Pointers, counters and sync history are also 0.
- **Reset mid-operation:** the FIFO content is discarded and `overflow_cnt` is cleared.
- **Latency:** a corner pixel accepted at edge E0 is captured at E0 and written at E1. With an empty FIFO, `kp_valid`=1 after E1.
- **Throughput:** one keypoint per cycle in, one per cycle out. A full FIFO with a pop every cycle never drops.
- **Stall:** `TVALID_in`=0 while the push flag is set:
  - The capture register holds and does not re-push.
  - The push flag clears after its single write attempt.
- **Frame-end pulse:** `frame_done` is high for exactly one `clk` cycle, even if `TVALID_in` drops the next cycle.
- **Simultaneous pop and push on an empty FIFO:** impossible, because `kp_valid`=0.
- **Simultaneous pop and push on a non-empty FIFO:** occupancy is unchanged.

## Test plan
1. **Reset and single keypoint:**
   - Reset, then width=8, one frame of 4 rows, TVALID_in always 1, score 0x55 at the pixel with index 19.
   - Expect one record x=3, y=2, score=0x55, with kp_valid high 2 edges after that pixel.
   - Expect frame_kp_count=1 and frame_done as a single pulse.
2. **Stall freeze:**
   - Same frame as test 1, with TVALID_in toggling 1/0 every cycle.
   - Expect identical records and count.
   - Expect no duplicate record while TVALID_in=0 with a capture pending.
3. **Backpressure and overflow:**
   - FIFO_DEPTH=4, kp_ready=0, 6 consecutive corner pixels with scores 1..6.
   - Expect the FIFO to hold 1..4, overflow_cnt=2 and frame_kp_count=6.
   - Then raise kp_ready: expect records in order 1,2,3,4 with stable data between pops.
4. **Full with concurrent pop:**
   - Fill the FIFO with kp_ready=0, then assert kp_ready in the same cycle a new keypoint is written.
   - Expect no drop and overflow_cnt unchanged.
5. **Line wrap and frame restart:**
   - width=1, 3 pixels: expect (0,0), (0,1), (0,2).
   - Then a new V_SYNC rising edge: expect the next keypoint at (0,0).
6. **Asynchronous reset mid-frame:**
   - Assert rst with 3 records queued.
   - Expect kp_valid=0 and all counters 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/nms_keypoint_packer.sv
// nms_keypoint_packer: turns the suppressed NMS score stream into
// (x, y, score) keypoint records queued behind a valid/ready port.
module nms_keypoint_packer #(
   parameter int FIFO_DEPTH = 16,
   parameter int COORD_W    = 11,
   parameter int SCORE_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_V_SYNC,
   input  logic               in_data_en,
   input  logic [SCORE_W-1:0] in_score,
   input  logic               TVALID_in,
   input  logic [COORD_W-1:0] width,
   output logic               kp_valid,
   input  logic               kp_ready,
   output logic [COORD_W-1:0] kp_x,
   output logic [COORD_W-1:0] kp_y,
   output logic [SCORE_W-1:0] kp_score,
   output logic               frame_done,
   output logic [15:0]        frame_kp_count,
   output logic [15:0]        overflow_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int RW = 2 * COORD_W + SCORE_W;
   localparam logic [COORD_W-1:0] C_ONE = {{(COORD_W-1){1'b0}}, 1'b1};
   localparam logic [AW:0]        P_ONE = {{AW{1'b0}}, 1'b1};

   logic               vs_q;
   logic [COORD_W-1:0] x_q;
   logic [COORD_W-1:0] y_q;
   logic [COORD_W-1:0] cur_x;
   logic [COORD_W-1:0] cur_y;
   logic [15:0]        run_q;
   logic [15:0]        run_base;
   logic [15:0]        run_nxt;
   logic               rise;
   logic               fall;
   logic               accept;
   logic               det;

   logic               cap_push;
   logic [COORD_W-1:0] cap_x;
   logic [COORD_W-1:0] cap_y;
   logic [SCORE_W-1:0] cap_score;

   logic [RW-1:0]      mem [FIFO_DEPTH];
   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic               empty;
   logic               full;
   logic               pop;
   logic               push;
   logic               drop;
   logic [RW-1:0]      head;

   // Input-side qualification: edges, accepted pixel, coordinates, count
   always_comb begin
      rise     = TVALID_in & in_V_SYNC & ~vs_q;
      fall     = TVALID_in & ~in_V_SYNC & vs_q;
      accept   = TVALID_in & in_data_en;
      det      = accept & (in_score != '0);
      cur_x    = rise ? '0 : x_q;
      cur_y    = rise ? '0 : y_q;
      run_base = rise ? 16'd0 : run_q;
      run_nxt  = run_base;
      if (det && (run_base != 16'hFFFF))
         run_nxt = run_base + 16'd1;
   end

   // Sync history, raster position and running keypoint count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_q  <= 1'b0;
         x_q   <= '0;
         y_q   <= '0;
         run_q <= 16'd0;
      end else if (TVALID_in) begin
         vs_q  <= in_V_SYNC;
         run_q <= run_nxt;
         if (accept) begin
            if (cur_x == width - C_ONE) begin
               x_q <= '0;
               y_q <= cur_y + C_ONE;
            end else begin
               x_q <= cur_x + C_ONE;
               y_q <= cur_y;
            end
         end else if (rise) begin
            x_q <= '0;
            y_q <= '0;
         end
      end
   end

   // Capture stage; the push flag lives for exactly one write attempt
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_push  <= 1'b0;
         cap_x     <= '0;
         cap_y     <= '0;
         cap_score <= '0;
      end else if (TVALID_in) begin
         cap_push <= det;
         if (det) begin
            cap_x     <= cur_x;
            cap_y     <= cur_y;
            cap_score <= in_score;
         end
      end else begin
         cap_push <= 1'b0;
      end
   end

   // Frame-end pulse and latched per-frame count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_done     <= 1'b0;
         frame_kp_count <= 16'd0;
      end else begin
         frame_done <= fall;
         if (fall)
            frame_kp_count <= run_nxt;
      end
   end

   // FIFO status and write/drop decision
   always_comb begin
      empty = (wr_ptr == rd_ptr);
      full  = (wr_ptr[AW] != rd_ptr[AW]) &&
              (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      pop   = ~empty & kp_ready;
      push  = cap_push & (~full | pop);
      drop  = cap_push & ~push;
   end

   // FIFO pointers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + P_ONE;
         if (pop)
            rd_ptr <= rd_ptr + P_ONE;
      end
   end

   // FIFO storage; contents are only visible through valid entries
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= {cap_x, cap_y, cap_score};
   end

   // Saturating dropped-keypoint counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overflow_cnt <= 16'd0;
      else if (drop && (overflow_cnt != 16'hFFFF))
         overflow_cnt <= overflow_cnt + 16'd1;
   end

   // Show-ahead head; fields forced to zero while empty
   always_comb begin
      head     = mem[rd_ptr[AW-1:0]];
      kp_valid = ~empty;
      kp_x     = '0;
      kp_y     = '0;
      kp_score = '0;
      if (kp_valid) begin
         kp_x     = head[RW-1 -: COORD_W];
         kp_y     = head[SCORE_W +: COORD_W];
         kp_score = head[SCORE_W-1:0];
      end
   end

endmodule
